// File: rtl/cpu_seq_ctrl.sv
// Instruction sequencer for the 10-bit CPU: a fixed FETCH/DECODE/EXEC/WB sequence per instruction.
// It drives the PC load, the IR capture, the ALU control and the register-file write strobes.
module cpu_seq_ctrl #(
    parameter int IW    = 10,
    parameter int PC_W  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step_mode,
    input  logic [IW-1:0]    instr_in,
    input  logic [PC_W-1:0]  pc_addr,
    input  logic             zero_flag,
    output logic             pc_load_en,
    output logic [PC_W-1:0]  pc_next,
    output logic             ir_load,
    output logic             alu_en,
    output logic [2:0]       alu_op,
    output logic             imm_sel,
    output logic [1:0]       rd_sel,
    output logic [1:0]       rs_sel,
    output logic [3:0]       imm,
    output logic             reg_we,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED
    } state_t;

    localparam logic [3:0] OP_LOAD = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_AND = 4'h4,
                           OP_OR   = 4'h5, OP_MOV = 4'h6, OP_JMP = 4'h7, OP_JZ  = 4'h8,
                           OP_JNZ  = 4'h9, OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                           ALU_OR  = 3'b011, ALU_PASS = 3'b100;

    state_t            state, state_nxt;
    logic [IW-1:0]     ir;
    logic [3:0]        opcode;
    logic [2:0]        dec_op;
    logic              dec_alu;
    logic [PC_W-1:0]   pc_seq;
    logic [PC_W-1:0]   pc_tgt;

    assign opcode = ir[IW-1:IW-4];
    assign pc_seq = pc_addr + PC_W'(1);
    assign pc_tgt = PC_W'(ir[3:0]);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            ir          <= '0;
            retired_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH)
                ir <= instr_in;
            if (state == S_WB && retired_cnt != '1)
                retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    // ALU class and operation of the instruction held in the IR.
    always_comb begin
        dec_alu = 1'b1;
        dec_op  = ALU_ADD;
        case (opcode)
            OP_LOAD: dec_op = ALU_PASS;
            OP_ADD:  dec_op = ALU_ADD;
            OP_SUB:  dec_op = ALU_SUB;
            OP_AND:  dec_op = ALU_AND;
            OP_OR:   dec_op = ALU_OR;
            OP_MOV:  dec_op = ALU_PASS;
            default: dec_alu = 1'b0;
        endcase
    end

    // NOTE: every output is given a default before the case, so no latch can be inferred.
    always_comb begin
        state_nxt  = state;
        pc_load_en = 1'b0;
        pc_next    = '0;
        ir_load    = 1'b0;
        alu_en     = 1'b0;
        alu_op     = ALU_ADD;
        imm_sel    = 1'b0;
        rd_sel     = '0;
        rs_sel     = '0;
        imm        = '0;
        reg_we     = 1'b0;
        illegal    = 1'b0;
        busy       = state inside {S_FETCH, S_DECODE, S_EXEC, S_WB};
        halted     = (state == S_HALTED);

        // The decoded fields are held from DECODE through WB and are quiet otherwise.
        if (state inside {S_DECODE, S_EXEC, S_WB}) begin
            rd_sel  = ir[5:4];
            rs_sel  = ir[3:2];
            imm     = ir[3:0];
            alu_op  = dec_op;
            imm_sel = (opcode == OP_LOAD);
        end

        case (state)
            S_IDLE: begin
                if (run)
                    state_nxt = S_FETCH;
            end
            S_FETCH: begin
                ir_load   = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                state_nxt = (opcode == OP_HALT) ? S_HALTED : S_EXEC;
            end
            S_EXEC: begin
                alu_en    = dec_alu;
                state_nxt = S_WB;
            end
            S_WB: begin
                reg_we     = dec_alu;
                pc_load_en = 1'b1;
                illegal    = opcode inside {[4'hA:4'hE]};
                case (opcode)
                    OP_JMP:  pc_next = pc_tgt;
                    OP_JZ:   pc_next = zero_flag ? pc_tgt : pc_seq;
                    OP_JNZ:  pc_next = zero_flag ? pc_seq : pc_tgt;
                    default: pc_next = pc_seq;
                endcase
                state_nxt = step_mode ? S_IDLE : S_FETCH;
            end
            S_HALTED: begin
                state_nxt = S_HALTED;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: table-driven single-step vectors followed by
// hand-written HALT, mid-instruction reset, free-run latency and counter-saturation sequences.
module tb_cpu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       step_mode;
    logic [9:0] instr_in;
    logic [3:0] pc_addr;
    logic       zero_flag;
    logic       pc_load_en;
    logic [3:0] pc_next;
    logic       ir_load;
    logic       alu_en;
    logic [2:0] alu_op;
    logic       imm_sel;
    logic [1:0] rd_sel;
    logic [1:0] rs_sel;
    logic [3:0] imm;
    logic       reg_we;
    logic       busy;
    logic       halted;
    logic       illegal;
    logic [7:0] retired_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    cpu_seq_ctrl #(.IW(10), .PC_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .run(run), .step_mode(step_mode),
        .instr_in(instr_in), .pc_addr(pc_addr), .zero_flag(zero_flag),
        .pc_load_en(pc_load_en), .pc_next(pc_next), .ir_load(ir_load),
        .alu_en(alu_en), .alu_op(alu_op), .imm_sel(imm_sel),
        .rd_sel(rd_sel), .rs_sel(rs_sel), .imm(imm), .reg_we(reg_we),
        .busy(busy), .halted(halted), .illegal(illegal), .retired_cnt(retired_cnt)
    );

    typedef struct {
        logic [9:0] instr;
        logic [3:0] pc;
        logic       zf;
        logic       alu_en;
        logic [2:0] alu_op;
        logic       imm_sel;
        logic       reg_we;
        logic [3:0] pc_next;
        logic       illegal;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [3:0] imm;
    } vec_t;

    vec_t vecs[16];
    int   n_vec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction in step mode, starting and ending in IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        instr_in  = v.instr;
        pc_addr   = v.pc;
        zero_flag = v.zf;
        step_mode = 1'b1;
        run       = 1'b1;
        tick();
        run = 1'b0;
        check({tag, " fetch ir_load"}, ir_load, 1);
        check({tag, " fetch busy"}, busy, 1);
        tick();
        check({tag, " decode rd_sel"}, rd_sel, v.rd);
        check({tag, " decode rs_sel"}, rs_sel, v.rs);
        check({tag, " decode imm"}, imm, v.imm);
        check({tag, " decode alu_en"}, alu_en, 0);
        tick();
        check({tag, " exec alu_en"}, alu_en, v.alu_en);
        check({tag, " exec alu_op"}, alu_op, v.alu_op);
        check({tag, " exec imm_sel"}, imm_sel, v.imm_sel);
        check({tag, " exec reg_we"}, reg_we, 0);
        check({tag, " exec pc_load_en"}, pc_load_en, 0);
        tick();
        check({tag, " wb reg_we"}, reg_we, v.reg_we);
        check({tag, " wb pc_load_en"}, pc_load_en, 1);
        check({tag, " wb pc_next"}, pc_next, v.pc_next);
        check({tag, " wb illegal"}, illegal, v.illegal);
        check({tag, " wb rd_sel"}, rd_sel, v.rd);
        check({tag, " wb alu_en"}, alu_en, 0);
        tick();
        exp_cnt++;
        check({tag, " idle busy"}, busy, 0);
        check({tag, " idle pc_load_en"}, pc_load_en, 0);
        check({tag, " retired_cnt"}, retired_cnt, exp_cnt);
    endtask

    initial begin
        //            instr          pc     zf    alu_en op      isel  we    next   ill   rd     rs     imm
        vecs[0]  = '{10'b0001_01_0101, 4'd0,  1'b0, 1'b1, 3'b100, 1'b1, 1'b1, 4'd1,  1'b0, 2'b01, 2'b01, 4'h5};
        vecs[1]  = '{10'b0111_00_1010, 4'd3,  1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'hA,  1'b0, 2'b00, 2'b10, 4'hA};
        vecs[2]  = '{10'b1000_00_0111, 4'd2,  1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 4'd7,  1'b0, 2'b00, 2'b01, 4'h7};
        vecs[3]  = '{10'b1000_00_0111, 4'd2,  1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd3,  1'b0, 2'b00, 2'b01, 4'h7};
        vecs[4]  = '{10'b1001_00_0111, 4'd2,  1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd7,  1'b0, 2'b00, 2'b01, 4'h7};
        vecs[5]  = '{10'b1001_00_0111, 4'd2,  1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 4'd3,  1'b0, 2'b00, 2'b01, 4'h7};
        vecs[6]  = '{10'b0000_00_0000, 4'd15, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0,  1'b0, 2'b00, 2'b00, 4'h0};
        vecs[7]  = '{10'b1100_10_0110, 4'd6,  1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd7,  1'b1, 2'b10, 2'b01, 4'h6};
        vecs[8]  = '{10'b0010_10_1100, 4'd4,  1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 4'd5,  1'b0, 2'b10, 2'b11, 4'hC};
        vecs[9]  = '{10'b0011_11_0100, 4'd5,  1'b1, 1'b1, 3'b001, 1'b0, 1'b1, 4'd6,  1'b0, 2'b11, 2'b01, 4'h4};
        vecs[10] = '{10'b0100_00_1000, 4'd8,  1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 4'd9,  1'b0, 2'b00, 2'b10, 4'h8};
        vecs[11] = '{10'b0101_01_0000, 4'd14, 1'b0, 1'b1, 3'b011, 1'b0, 1'b1, 4'd15, 1'b0, 2'b01, 2'b00, 4'h0};
        vecs[12] = '{10'b0110_11_0100, 4'd15, 1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 4'd0,  1'b0, 2'b11, 2'b01, 4'h4};
        vecs[13] = '{10'b1010_01_0001, 4'd1,  1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd2,  1'b1, 2'b01, 2'b00, 4'h1};
        vecs[14] = '{10'b1110_00_0011, 4'd9,  1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 4'hA,  1'b1, 2'b00, 2'b00, 4'h3};
        vecs[15] = '{10'b0111_00_0000, 4'd15, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0,  1'b0, 2'b00, 2'b00, 4'h0};
        n_vec = 16;

        rst = 1'b0; run = 1'b0; step_mode = 1'b0;
        instr_in = '0; pc_addr = '0; zero_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset halted", halted, 0);
        check("reset retired_cnt", retired_cnt, 0);
        check("reset strobes", {pc_load_en, ir_load, alu_en, reg_we, illegal}, 0);
        check("reset fields", {pc_next, alu_op, rd_sel, rs_sel, imm}, 0);
        rst = 1'b1;
        tick();
        check("idle after reset busy", busy, 0);
        check("idle no ir_load", ir_load, 0);

        for (int i = 0; i < n_vec; i++)
            run_vec(vecs[i], i);

        // step_mode: stays in IDLE without run.
        repeat (3) begin
            tick();
            check("step idle wait busy", busy, 0);
        end

        // HALT at pc 9: parks in HALTED, ignores run, no PC load, not retired.
        instr_in = 10'b1111_00_0000; pc_addr = 4'd9; step_mode = 1'b0; run = 1'b1;
        tick();
        run = 1'b0;
        check("halt fetch ir_load", ir_load, 1);
        tick();
        check("halt decode busy", busy, 1);
        tick();
        for (int i = 0; i < 20; i++) begin
            run = i[0];
            check("halted flag", halted, 1);
            check("halted busy", busy, 0);
            check("halted pc_load_en", pc_load_en, 0);
            check("halted ir_load", ir_load, 0);
            tick();
        end
        run = 1'b0;
        check("halt not retired", retired_cnt, exp_cnt);

        rst = 1'b0;
        #1;
        check("reset exits halt", halted, 0);
        check("reset clears cnt", retired_cnt, 0);
        rst = 1'b1;
        exp_cnt = 0;

        // Reset asserted in EXEC aborts the instruction.
        instr_in = 10'b0001_01_0101; pc_addr = 4'd0; step_mode = 1'b0; run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        check("abort exec alu_en", alu_en, 1);
        rst = 1'b0;
        #1;
        check("abort immediate strobes", {pc_load_en, ir_load, alu_en, reg_we, illegal}, 0);
        check("abort immediate fields", {pc_next, alu_op, rd_sel, rs_sel, imm}, 0);
        check("abort immediate busy", busy, 0);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("abort no pc_load_en", pc_load_en, 0);
            check("abort no reg_we", reg_we, 0);
            check("abort busy", busy, 0);
        end
        check("abort retired_cnt", retired_cnt, 0);

        // Free-running NOPs with run held high: one PC load every 4 cycles, counter saturates.
        instr_in = 10'b0000_00_0000; pc_addr = 4'd0; step_mode = 1'b0; run = 1'b1;
        for (int c = 0; c < 1040; c++) begin
            tick();
            if (c < 40) begin
                check("free-run pc_load_en", pc_load_en, (c % 4 == 3) ? 1 : 0);
                check("free-run busy", busy, 1);
            end
        end
        check("free-run final wb", pc_load_en, 1);
        check("retired_cnt saturates", retired_cnt, 8'hFF);
        step_mode = 1'b1;
        run = 1'b0;
        tick();
        check("step after wb idle", busy, 0);
        check("saturated holds", retired_cnt, 8'hFF);
        tick();
        check("step idle holds", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
